// File: rtl/memlog_dump.sv
// Read-side dump engine for the BRAM capture logger: sweeps an address window after the
// logger fills and streams each word MSB-byte-first over a valid/ready byte interface.
module memlog_dump #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [BRAM_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [BRAM_ADDR_WIDTH:0]   i_num_words,
    input  logic                       i_mem_full,
    input  logic [BRAM_DATA_WIDTH-1:0] i_data_log_from_mem,
    output logic                       o_read_log,
    output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem,
    output logic [7:0]                 o_tx_data,
    output logic                       o_tx_valid,
    input  logic                       i_tx_ready,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);
    localparam int AW     = BRAM_ADDR_WIDTH;
    localparam int DW     = BRAM_DATA_WIDTH;
    localparam int NBYTES = DW / 8;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CAP   = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [AW:0]   DEPTH    = {1'b1, {AW{1'b0}}};
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   rem_q, rem_d;
    logic [DW-1:0] word_q, word_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          read_q, read_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        word_d     = word_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        err_d      = err_q;
        read_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_valid_d = 1'b0;
                if (i_start) begin
                    if (!i_mem_full) begin
                        err_d = 1'b1;
                    end else begin
                        err_d  = 1'b0;
                        busy_d = 1'b1;
                        if (i_num_words == '0) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            addr_d  = i_base_addr;
                            rem_d   = (i_num_words > DEPTH) ? DEPTH : i_num_words;
                            read_d  = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_FETCH: state_d = S_CAP;
            S_CAP: begin
                // First byte is presented straight from the read data; the rest shift out of word_q.
                tx_data_d  = i_data_log_from_mem[DW-1 -: 8];
                word_d     = i_data_log_from_mem << 8;
                idx_d      = '0;
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (tx_valid_q && i_tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        tx_valid_d = 1'b0;
                        if (rem_q > (AW+1)'(1)) begin
                            rem_d   = rem_q - (AW+1)'(1);
                            addr_d  = addr_q + AW'(1);
                            state_d = S_FETCH;
                        end else begin
                            rem_d   = '0;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end else begin
                        idx_d     = idx_q + IW'(1);
                        tx_data_d = word_q[DW-1 -: 8];
                        word_d    = word_q << 8;
                    end
                end
            end
            S_DONE: begin
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            read_q     <= read_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_read_log        = read_q;
    assign o_addr_log_to_mem = addr_q;
    assign o_tx_data         = tx_data_q;
    assign o_tx_valid        = tx_valid_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;
    assign o_err             = err_q;

endmodule
